// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  // state    | meaning
  // ST_IDLE  | waiting for mem_req_valid; captures the word index on acceptance
  // ST_WAIT  | latency countdown (plus optional random stall cycles)
  // ST_RESP  | mem_req_ready pulse; mem_req_rdata valid
  // ST_DRAIN | ignore the initiator's trailing valid until it drops
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/imem_array.sv
// MEM_WORDS x 32 word store: one synchronous backdoor write port and one
// read port whose output register loads only when rd_en is pulsed.
// A write and a read of the same word on the same edge return the old data.
module imem_array #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
  input  logic [31:0]                  wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [31:0]                  rd_data
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Storage is intentionally not reset; contents survive resetn.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Read register holds its value between captures.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  // Read data register with async reset to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch miss interface: one word per
// request after a fixed LATENCY, then a drain state that swallows the
// initiator's trailing valid cycle.
// Optional build macro: IMEM_RESP_STALL_EN adds LFSR-driven random stall
// cycles (1..3) before some responses.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_req_valid,
  output logic                         mem_req_ready,
  input  logic [31:0]                  mem_req_addr,
  output logic [31:0]                  mem_req_rdata,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic                         oor_err,
  output logic [31:0]                  req_count
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  imem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          oor_pend_q, oor_pend_d;
  logic          resp_oor_q, resp_oor_d;
  logic          oor_err_q, oor_err_d;
  logic [31:0]   req_count_q, req_count_d;

  logic [31:0]   word_off;
  logic          req_oor;
  logic          enter_resp;
  logic          resp_oor_src;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   arr_rdata;

`ifdef IMEM_RESP_STALL_EN
  logic [15:0]   lfsr_q, lfsr_d;
  logic          stall_q, stall_d;
`endif

  // Unsigned wrap makes addresses below ADDR_BASE land out of range too.
  assign word_off = (mem_req_addr - ADDR_BASE) >> 2;
  assign req_oor  = (word_off >= 32'(MEM_WORDS));

`ifdef IMEM_RESP_STALL_EN
  // Free-running LFSR that decides when to stretch a response.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end
`endif

  // Next-state, countdown and response capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    oor_pend_d   = oor_pend_q;
    resp_oor_d   = resp_oor_q;
    oor_err_d    = oor_err_q;
    req_count_d  = req_count_q;
    enter_resp   = 1'b0;
    resp_oor_src = oor_pend_q;
    rd_idx       = idx_q;
`ifdef IMEM_RESP_STALL_EN
    stall_d      = stall_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mem_req_valid) begin
          idx_d      = word_off[AW-1:0];
          oor_pend_d = req_oor;
          cnt_d      = LAT_M1;
`ifdef IMEM_RESP_STALL_EN
          stall_d    = 1'b0;
`endif
          if (LATENCY == 1) begin
            enter_resp   = 1'b1;
            rd_idx       = word_off[AW-1:0];
            resp_oor_src = req_oor;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
`ifdef IMEM_RESP_STALL_EN
          if (!stall_q && lfsr_q[0]) begin
            stall_d = 1'b1;
            cnt_d   = (lfsr_q[2:1] == 2'd0) ? 4'd1 : {2'b00, lfsr_q[2:1]};
          end else begin
            enter_resp = 1'b1;
          end
`else
          enter_resp = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_req_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_en = enter_resp;
    if (enter_resp) begin
      state_d     = ST_RESP;
      resp_oor_d  = resp_oor_src;
      req_count_d = req_count_q + 32'd1;
      if (resp_oor_src) begin
        oor_err_d = 1'b1;
      end
    end
  end

  // State and status registers, abandoned cleanly on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      oor_pend_q  <= 1'b0;
      resp_oor_q  <= 1'b0;
      oor_err_q   <= 1'b0;
      req_count_q <= '0;
`ifdef IMEM_RESP_STALL_EN
      lfsr_q      <= LFSR_SEED;
      stall_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      oor_pend_q  <= oor_pend_d;
      resp_oor_q  <= resp_oor_d;
      oor_err_q   <= oor_err_d;
      req_count_q <= req_count_d;
`ifdef IMEM_RESP_STALL_EN
      lfsr_q      <= lfsr_d;
      stall_q     <= stall_d;
`endif
    end
  end

  imem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (load_en),
    .wr_idx  (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (arr_rdata)
  );

  assign mem_req_ready = (state_q == ST_RESP);
  assign mem_req_rdata = resp_oor_q ? NOP_INSTR : arr_rdata;
  assign oor_err       = oor_err_q;
  assign req_count     = req_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed cases plus randomized
// requests against a word-array reference model. Honors IMEM_RESP_STALL_EN.
module tb_imem_responder;

  localparam int          MEM_WORDS = 1024;
  localparam int          LAT       = 2;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
`ifdef IMEM_RESP_STALL_EN
  localparam int          N_RAND    = 1000;
`else
  localparam int          N_RAND    = 200;
`endif

  logic        clk;
  logic        resetn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        oor_err;
  logic [31:0] req_count;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] model_count;
  logic        model_oor;
  int          n_checks;
  int          n_fail;

  imem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LAT),
    .ADDR_BASE (BASE)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdata (mem_req_rdata),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .oor_err       (oor_err),
    .req_count     (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic do_load(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    @(negedge clk);
    load_en   = 1'b0;
    model_mem[idx] = data;
  endtask

  // One full handshake: raise valid, wait for ready, hold valid for the
  // trailing cycle plus hold_extra more, then drop it.
  task automatic do_req(input logic [31:0] addr, input int hold_extra);
    logic [31:0] idx;
    logic [31:0] exp_data;
    logic        exp_oor;
    logic        seen;
    int          n;
    idx      = (addr - BASE) >> 2;
    exp_oor  = (idx >= MEM_WORDS);
    exp_data = exp_oor ? NOP : model_mem[idx[9:0]];
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr  = addr;
    @(posedge clk);
    #1;
    mem_req_addr = $urandom;
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (mem_req_ready) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    model_count = model_count + 32'd1;
    if (exp_oor) model_oor = 1'b1;
    check("ready_seen", {31'd0, seen}, 32'd1);
    check("rdata", mem_req_rdata, exp_data);
`ifdef IMEM_RESP_STALL_EN
    check("latency_range", {31'd0, (n >= LAT && n <= LAT + 3)}, 32'd1);
`else
    check("latency", n, LAT);
`endif
    @(posedge clk);
    #1;
    check("ready_one_cycle", {31'd0, mem_req_ready}, 32'd0);
    check("rdata_hold", mem_req_rdata, exp_data);
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk);
      #1;
      check("no_spurious_ready", {31'd0, mem_req_ready}, 32'd0);
    end
    @(negedge clk);
    mem_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("no_spurious_ready", {31'd0, mem_req_ready}, 32'd0);
    check("req_count", req_count, model_count);
    check("oor_err", {31'd0, oor_err}, {31'd0, model_oor});
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] old7;
    n_checks      = 0;
    n_fail        = 0;
    model_count   = 32'd0;
    model_oor     = 1'b0;
    resetn        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'd0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, mem_req_ready}, 32'd0);
    check("rst_rdata", mem_req_rdata, 32'd0);
    check("rst_oor", {31'd0, oor_err}, 32'd0);
    check("rst_count", req_count, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Preload the whole array through the backdoor.
    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h0 : $urandom;
      model_mem[i] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;

    do_req(32'h0000_0014, 0);
    do_req(32'h0000_0018, 0);
    do_req(32'h0000_1000, 1);
    do_req(32'h0000_0020, 2);
    do_req(32'h0000_0023, 0);

`ifndef IMEM_RESP_STALL_EN
    // Backdoor write to index 7 on the same edge the response is captured.
    old7 = model_mem[7];
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr  = 32'h0000_001C;
    repeat (LAT - 1) @(negedge clk);
    load_en   = 1'b1;
    load_addr = 10'd7;
    load_data = 32'h12345678;
    @(posedge clk);
    #1;
    model_count = model_count + 32'd1;
    check("coll_ready", {31'd0, mem_req_ready}, 32'd1);
    check("coll_old_data", mem_req_rdata, old7);
    @(negedge clk);
    load_en       = 1'b0;
    mem_req_valid = 1'b0;
    model_mem[7]  = 32'h12345678;
    @(posedge clk);
    #1;
    check("coll_ready_drop", {31'd0, mem_req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("coll_count", req_count, model_count);
    do_req(32'h0000_001C, 0);
`endif

    // Reset during WAIT abandons the transaction.
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_addr  = 32'h0000_0024;
    @(posedge clk);
    #1;
    check("midrst_pre_ready", {31'd0, mem_req_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_count = 32'd0;
    model_oor   = 1'b0;
    check("midrst_ready", {31'd0, mem_req_ready}, 32'd0);
    check("midrst_count", req_count, model_count);
    check("midrst_oor", {31'd0, oor_err}, {31'd0, model_oor});
    check("midrst_rdata", mem_req_rdata, 32'd0);
    @(negedge clk);
    mem_req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_ready", {31'd0, mem_req_ready}, 32'd0);
    end
    check("midrst_count_after", req_count, model_count);
    do_req(32'h0000_0024, 0);

    // Randomized traffic with occasional backdoor writes between requests.
    for (int r = 0; r < N_RAND; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(10'($urandom_range(0, MEM_WORDS - 1)), $urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        addr = $urandom;
        if (addr < 32'h0000_1000) addr = addr | 32'h0000_1000;
      end else begin
        addr = {20'd0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'($urandom)};
      end
      do_req(addr, $urandom_range(0, 2));
    end
    check("final_count", req_count, model_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction-fetch miss interface (mem_req_valid / mem_req_ready / mem_req_addr / mem_req_rdata) that the compressing fetch controller drives.
- Serves one 32-bit word per request from an internal word array, with programmable fixed latency.
- Array is preloaded through a backdoor write port.
- Used as the instruction-memory model in simulation and as the on-chip boot memory in FPGA builds.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request acceptance to the ready pulse; legal range 1..15.
- ADDR_BASE, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- mem_req_valid  in  1  request pending; level signal held by the initiator until the ready pulse is seen.
- mem_req_ready  out  1  one-cycle pulse; mem_req_rdata is valid in the same cycle.
- mem_req_addr  in  32  byte address, sampled at acceptance only.
- mem_req_rdata  out  32  read data; holds its last value when ready is low.
- load_en  in  1  backdoor write strobe.
- load_addr  in  $clog2(MEM_WORDS)  backdoor word index.
- load_data  in  32  backdoor write data.
- oor_err  out  1  sticky flag: a request fell outside the array.
- req_count  out  32  number of completed responses; wraps at 2^32.

Behaviour:
- Reset values (asynchronous, applied while resetn=0):
  - mem_req_ready=0, mem_req_rdata=0, oor_err=0, req_count=0.
  - FSM goes to IDLE; latency counter cleared.
  - Array contents are NOT reset.
- Reset asserted mid-transaction: the transaction is abandoned; no ready pulse is produced after reset releases unless a new request is accepted.
- FSM states: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - On an edge with mem_req_valid=1: capture the word index, load cnt=LATENCY-1, go to WAIT (or RESP if LATENCY=1).
  - The captured index is (mem_req_addr-ADDR_BASE)>>2; addr[1:0] are ignored.
- WAIT:
  - Decrement cnt each cycle; go to RESP when cnt reaches 0.
  - Deassertion of mem_req_valid during WAIT is a protocol violation; the response still completes.
- Transition into RESP:
  - Register mem_req_rdata = array[index].
  - If the index is >= MEM_WORDS (computed with 32-bit unsigned arithmetic, so addresses below ADDR_BASE also qualify): drive 32'h0000_0013 (NOP) and set oor_err.
- RESP:
  - mem_req_ready=1 for exactly this one cycle; req_count increments on the same edge.
  - Next state is DRAIN.
- DRAIN:
  - mem_req_ready=0. The initiator's valid is still high for one cycle after it samples ready; that valid must NOT be taken as a new request.
  - Stay in DRAIN while mem_req_valid=1; go to IDLE on the first cycle with mem_req_valid=0.
  - Result: back-to-back requests are separated by at least one valid-low cycle.
- Latency: request accepted at edge k gives ready high in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Backdoor writes:
  - load_en writes the array at any time, in any state.
  - A write to the word being read on the same edge as the RESP capture returns the OLD data.
  - The new value is visible to requests captured on later edges.
- oor_err clears only on reset.

Optional Feature:
- Macro: IMEM_RESP_STALL_EN.
- Defined:
  - A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - On WAIT→RESP, if lfsr[0]=1, insert 1..3 extra wait cycles (count = lfsr[2:1], with 0 treated as 1) before RESP.
  - Exercises initiator tolerance of variable latency.
- Undefined: latency is exactly LATENCY; no LFSR is present.

Decomposition:
- Package imem_pkg:
  - FSM state typedef (2 bits: IDLE, WAIT, RESP, DRAIN).
  - NOP_INSTR = 32'h0000_0013.
  - LFSR seed and taps constants.
- Sub-module imem_array: MEM_WORDS x 32 storage with one synchronous write port (load) and one read port registered on the RESP capture edge.
- FSM, counters and error logic stay in imem_responder.

Test Plan:
- Preload word 5 = 32'hDEADBEEF, LATENCY=2; hold valid with addr 32'h14 → ready pulses 2 cycles after acceptance with rdata=32'hDEADBEEF; req_count=1.
- Initiator holds valid for one cycle after ready, then drops it for one cycle and re-requests addr 32'h18 → exactly one ready per request, none spurious; req_count=2.
- Request addr 32'h0000_1000 (index 1024, MEM_WORDS=1024) → rdata=32'h0000_0013, oor_err=1, and oor_err stays 1 after subsequent in-range reads.
- load_en to index 7 with 32'h12345678 on the same edge as the RESP capture for index 7 (old value 32'h0) → returns 32'h0; the next request returns 32'h12345678.
- resetn pulsed low during WAIT → ready stays 0 and req_count=0; no ready until a new request, which then completes normally.
- With IMEM_RESP_STALL_EN: 1000 requests → every response has latency between LATENCY and LATENCY+3, all data correct, req_count=1000.
